// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache trace driver
package cache_pkg;
  localparam int TRACE_ADDR_W = 48;
  localparam int TRACE_OP_W   = 8;
  localparam int COUNT_W      = 12;

  localparam logic [TRACE_OP_W-1:0] OP_READ  = 8'h52;
  localparam logic [TRACE_OP_W-1:0] OP_WRITE = 8'h57;

  typedef struct packed {
    logic [TRACE_ADDR_W-1:0] addr;
    logic [TRACE_OP_W-1:0]   op;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DONE
  } drv_state_e;

  function automatic logic op_legal(input logic [TRACE_OP_W-1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

  // Statistics stick at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == {COUNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - single-write-port trace memory with registered read data
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 56,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Only the read register is reset; array contents stay undefined.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end
endmodule

// File: rtl/cache_trace_driver.sv
// rtl/cache_trace_driver.sv - replays a loaded trace onto the cache request handshake
module cache_trace_driver
  import cache_pkg::*;
#(
  parameter int ADDR_W = TRACE_ADDR_W,
  parameter int OP_W   = TRACE_OP_W,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [PTR_W-1:0]   load_idx,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [OP_W-1:0]    load_op,
  input  logic               start,
  input  logic [PTR_W:0]     num_entries,
  input  logic               loop_en,
  input  logic               abort,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [ADDR_W-1:0]  cache_addr,
  output logic [OP_W-1:0]    cache_op,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] issued_count,
  output logic [COUNT_W-1:0] read_count,
  output logic [COUNT_W-1:0] write_count,
  output logic [COUNT_W-1:0] bad_op_count
);
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);

  drv_state_e            state;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W:0]        n_q;
  logic                  loop_q;
  logic                  abort_q;
  logic [ADDR_W+OP_W-1:0] rd_data;
  logic [PTR_W:0]        n_clamped;
  logic [PTR_W:0]        n_last;
  logic                  legal;
  logic                  last;
  logic                  stop;

  // The RAM read register doubles as the request payload register, so the
  // payload only moves in FETCH and is naturally held while ISSUE waits.
  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + OP_W),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_en && (state == ST_IDLE)),
    .wr_idx  (load_idx),
    .wr_data ({load_addr, load_op}),
    .rd_en   (state == ST_FETCH),
    .rd_idx  (ptr),
    .rd_data (rd_data)
  );

  assign {cache_addr, cache_op} = rd_data;
  assign legal     = op_legal(cache_op);
  assign req_valid = (state == ST_ISSUE) && legal;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign n_clamped = (num_entries > DEPTH_V) ? DEPTH_V : num_entries;
  assign n_last    = n_q - 1'b1;
  assign last      = ({1'b0, ptr} == n_last);
  assign stop      = abort || abort_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      n_q          <= '0;
      loop_q       <= 1'b0;
      abort_q      <= 1'b0;
      issued_count <= '0;
      read_count   <= '0;
      write_count  <= '0;
      bad_op_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_entries == '0) begin
              state <= ST_DONE;
            end else begin
              n_q          <= n_clamped;
              loop_q       <= loop_en;
              abort_q      <= 1'b0;
              ptr          <= '0;
              issued_count <= '0;
              read_count   <= '0;
              write_count  <= '0;
              bad_op_count <= '0;
              state        <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state <= abort ? ST_DONE : ST_ISSUE;
        ST_ISSUE: begin
          // Remember an abort seen while waiting; the pending request still completes.
          if (abort) abort_q <= 1'b1;
          if (!legal || req_ready) begin
            if (legal) begin
              issued_count <= sat_inc(issued_count);
              if (cache_op == OP_READ) read_count <= sat_inc(read_count);
              else write_count <= sat_inc(write_count);
            end else begin
              bad_op_count <= sat_inc(bad_op_count);
            end
            if (stop) begin
              state <= ST_DONE;
            end else if (last) begin
              ptr   <= '0;
              state <= loop_q ? ST_FETCH : ST_DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_trace_driver.sv
// tb/tb_cache_trace_driver.sv - randomized self-checking bench for cache_trace_driver
module tb_cache_trace_driver;
  localparam logic [7:0] R = 8'h52;
  localparam logic [7:0] W = 8'h57;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_idx;
  logic [47:0] load_addr;
  logic [7:0]  load_op;
  logic        start;
  logic [4:0]  num_entries;
  logic        loop_en;
  logic        abort;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] cache_addr;
  logic [7:0]  cache_op;
  logic        busy;
  logic        done;
  logic [11:0] issued_count, read_count, write_count, bad_op_count;

  cache_trace_driver dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_addr(load_addr), .load_op(load_op), .start(start),
    .num_entries(num_entries), .loop_en(loop_en), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .cache_addr(cache_addr),
    .cache_op(cache_op), .busy(busy), .done(done), .issued_count(issued_count),
    .read_count(read_count), .write_count(write_count), .bad_op_count(bad_op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [55:0] m_ram [16];
  logic [55:0] q[$];
  logic [55:0] pass_q[$];
  int  m_issued, m_read, m_write;
  bit  m_loop;
  bit  pend_start = 1'b0;
  int  pend_n;
  bit  pend_loop;
  bit  prev_done = 1'b0;
  int  done_count = 0;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c >= 4095) ? 4095 : c + 1;
  endfunction

  // Reference: the expected request stream is the legal entries of the first
  // min(n,16) trace slots, repeated when looping; counters follow handshakes.
  always @(negedge clk) begin
    logic [55:0] e;
    logic [7:0]  o;
    int nn;
    if (!reset) begin
      q.delete(); pass_q.delete();
      m_issued = 0; m_read = 0; m_write = 0; m_loop = 0;
      prev_done = 0; pend_start = 0;
    end else begin
      chk_eq("issued_count", issued_count, m_issued);
      chk_eq("read_count", read_count, m_read);
      chk_eq("write_count", write_count, m_write);
      if (req_valid) begin
        chk_eq("req_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q[0];
          chk_eq("req_entry", {cache_addr, cache_op}, e);
          if (req_ready) begin
            o = e[7:0];
            void'(q.pop_front());
            m_issued = sat(m_issued);
            if (o == R) m_read = sat(m_read); else m_write = sat(m_write);
            if (q.size() == 0 && m_loop) q = pass_q;
          end
        end
      end
      if (prev_done) begin
        chk_eq("done_single_cycle", done, 0);
        chk_eq("busy_after_done", busy, 0);
      end
      prev_done = done;
      if (done) done_count++;
      if (pend_start) begin
        pend_start = 0;
        if (pend_n != 0) begin
          m_issued = 0; m_read = 0; m_write = 0;
          m_loop = pend_loop;
          nn = (pend_n > 16) ? 16 : pend_n;
          pass_q.delete();
          for (int i = 0; i < nn; i++) begin
            e = m_ram[i];
            o = e[7:0];
            if (o == R || o == W) pass_q.push_back(e);
          end
          q = pass_q;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int idx, input logic [47:0] a, input logic [7:0] op);
    load_en = 1; load_idx = idx[3:0]; load_addr = a; load_op = op;
    m_ram[idx] = {a, op};
    cyc(1);
    load_en = 0;
  endtask

  task automatic start_run(input int n, input bit lp);
    start = 1; num_entries = n[4:0]; loop_en = lp;
    pend_n = n; pend_loop = lp; pend_start = 1;
    cyc(1);
    start = 0;
  endtask

  task automatic wait_done(input int max, input string name);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk_eq(name, done, 1);
  endtask

  task automatic wait_valid(input int max, input string name);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (req_valid) break;
    end
    chk_eq(name, req_valid, 1);
  endtask

  task automatic chk_counts(input string tag, input int iss, input int rd, input int wr, input int bad);
    chk_eq({tag, "_issued"}, issued_count, iss);
    chk_eq({tag, "_read"}, read_count, rd);
    chk_eq({tag, "_write"}, write_count, wr);
    chk_eq({tag, "_bad"}, bad_op_count, bad);
  endtask

  initial begin
    int hs, k, dc;
    reset = 0; load_en = 0; load_idx = 0; load_addr = 0; load_op = 0;
    start = 0; num_entries = 0; loop_en = 0; abort = 0; req_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_valid", req_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_addr", cache_addr, 0);
    chk_counts("rst", 0, 0, 0, 0);
    cyc(1);
    reset = 1;

    // Basic playback and start-to-valid latency
    load_entry(0, 48'h1000, R);
    load_entry(1, 48'h2040, W);
    load_entry(2, 48'h1000, R);
    dc = done_count;
    start_run(3, 0);
    @(negedge clk); chk_eq("lat_fetch_valid", req_valid, 0);
    @(negedge clk); chk_eq("lat_issue_valid", req_valid, 1);
    chk_eq("first_addr", cache_addr, 48'h1000);
    wait_done(40, "basic_done");
    chk_counts("basic", 3, 2, 1, 0);
    chk_eq("basic_all_issued", q.size(), 0);
    cyc(1);
    chk_eq("basic_done_once", done_count - dc, 1);

    // Backpressure, with a stray start and load while busy
    req_ready = 0;
    start_run(3, 0);
    wait_valid(10, "bp_valid");
    cyc(1);
    start = 1; num_entries = 1; load_en = 1; load_idx = 0;
    load_addr = 48'hDEAD; load_op = W;
    cyc(1);
    start = 0; load_en = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("bp_valid_held", req_valid, 1);
      chk_eq("bp_addr_stable", cache_addr, 48'h1000);
      chk_eq("bp_no_count", issued_count, 0);
    end
    cyc(1);
    req_ready = 1;
    wait_done(40, "bp_done");
    chk_counts("bp", 3, 2, 1, 0);
    cyc(1);

    // Illegal op skipped
    load_entry(1, 48'h2040, 8'h58);
    start_run(3, 0);
    wait_done(40, "bad_done");
    chk_counts("bad", 2, 2, 0, 1);
    cyc(1);

    // Loop with abort during the fifth request
    load_entry(0, 48'h3000, R);
    load_entry(1, 48'h3008, W);
    start_run(2, 1);
    hs = 0; k = 0;
    while (hs < 4 && k < 100) begin
      @(negedge clk); k++;
      if (req_valid && req_ready) hs++;
    end
    chk_eq("loop_hs4", hs, 4);
    cyc(1);
    req_ready = 0;
    wait_valid(10, "abort_pending_valid");
    cyc(1);
    abort = 1;
    cyc(3);
    @(negedge clk); chk_eq("abort_keeps_valid", req_valid, 1);
    cyc(1);
    req_ready = 1;
    wait_done(20, "abort_done");
    chk_counts("abort", 5, 3, 2, 0);
    cyc(1);
    abort = 0;
    @(negedge clk); chk_eq("abort_idle", busy, 0);
    cyc(1);

    // Zero-length start: done next cycle, counters untouched
    start_run(0, 0);
    @(negedge clk);
    chk_eq("n0_done", done, 1);
    chk_eq("n0_valid", req_valid, 0);
    chk_eq("n0_keep_issued", issued_count, 5);
    cyc(1);

    // Clamp 31 -> 16 with random addresses; slot 15 loaded in the start cycle
    for (int i = 0; i < 15; i++)
      load_entry(i, {16'h0, $urandom()}, (i % 2 == 0) ? R : W);
    req_ready = 1;
    load_en = 1; load_idx = 15; load_addr = 48'hF00; load_op = W;
    m_ram[15] = {48'hF00, W};
    start = 1; num_entries = 31; loop_en = 0;
    pend_n = 31; pend_loop = 0; pend_start = 1;
    cyc(1);
    load_en = 0; start = 0;
    wait_done(200, "clamp_done");
    chk_counts("clamp", 16, 8, 8, 0);
    cyc(1);

    // Random ready pattern over a random legal/illegal trace
    for (int i = 0; i < 8; i++)
      load_entry(i, {16'h0, $urandom()}, ($urandom_range(0, 3) == 0) ? 8'h41 : (($urandom_range(0, 1) == 1) ? R : W));
    start_run(8, 0);
    for (int i = 0; i < 200 && !done; i++) begin
      req_ready = $urandom_range(0, 1);
      cyc(1);
    end
    req_ready = 1;
    wait_done(40, "rand_done");
    chk_eq("rand_all_issued", q.size(), 0);
    cyc(1);

    // Saturation: 4200 looped requests
    load_entry(0, 48'h40, R);
    load_entry(1, 48'h80, W);
    start_run(2, 1);
    hs = 0; k = 0;
    while (hs < 4200 && k < 20000) begin
      @(negedge clk); k++;
      if (req_valid && req_ready) hs++;
    end
    chk_eq("sat_hs", hs, 4200);
    cyc(1);
    abort = 1;
    wait_done(10, "sat_done");
    chk_counts("sat", 12'hFFF, 2100, 2100, 0);
    cyc(1);
    abort = 0;

    // Asynchronous reset during a pending request
    load_entry(0, 48'h5000, R);
    start_run(1, 1);
    cyc(7);
    req_ready = 0;
    wait_valid(10, "rst_mid_valid");
    #2 reset = 0;
    #1;
    chk_eq("rst_mid_valid_low", req_valid, 0);
    chk_eq("rst_mid_busy_low", busy, 0);
    chk_eq("rst_mid_issued", issued_count, 0);
    chk_eq("rst_mid_read", read_count, 0);
    cyc(2);
    reset = 1;
    load_entry(0, 48'h6000, W);
    req_ready = 1;
    start_run(1, 0);
    wait_done(20, "rst_after_done");
    chk_counts("rst_after", 1, 0, 1, 0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
